// File: rtl/bus_sram_responder_pkg.sv
// ---------------------------------------------------------------------------
// bus_sram_responder_pkg
// Shared definitions for the bus-to-asynchronous-SRAM responder: the FSM state
// encoding and the default base of the reserved (non-SRAM) address window.
// ---------------------------------------------------------------------------
package bus_sram_responder_pkg;

  // Access sequencing states
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    ACK    = 2'd3
  } state_e;

  // Addresses from this value up to 16'hFFFF are not backed by SRAM
  localparam logic [15:0] EXCL_BASE_DEFAULT = 16'hFFF0;

endpackage

// File: rtl/bus_sram_responder.sv
// ---------------------------------------------------------------------------
// bus_sram_responder
// Turns a simple held-request bus access into a timed asynchronous SRAM
// cycle: one setup cycle, WAIT_STATES+1 strobe cycles and one ack cycle.
// Accesses to the reserved window EXCL_BASE..16'hFFFF never touch the SRAM
// and are acknowledged one cycle after the request is latched.
//
// Parameters
//   WAIT_STATES   extra strobe cycles per access (0..15)
//   EXCL_BASE     first address of the reserved window
// Ports
//   i_clk         clock, rising edge
//   i_reset       synchronous active-low reset
//   i_cs          access request, held by the master until o_ack
//   i_we          1 = write, 0 = read
//   i_addr        bus address
//   i_dat         bus write data
//   o_dat         registered read data
//   o_ack         one-cycle completion pulse
//   o_sram_addr   registered SRAM address
//   o_sram_dat    SRAM write data
//   o_sram_dat_oe SRAM data bus drive enable
//   i_sram_dat    SRAM read data
//   o_sram_ce_n   SRAM chip enable, active low
//   o_sram_oe_n   SRAM output enable, active low
//   o_sram_we_n   SRAM write enable, active low
// ---------------------------------------------------------------------------
module bus_sram_responder
  import bus_sram_responder_pkg::*;
#(
  parameter int unsigned WAIT_STATES = 2,
  parameter logic [15:0] EXCL_BASE   = EXCL_BASE_DEFAULT
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_cs,
  input  logic        i_we,
  input  logic [15:0] i_addr,
  input  logic [7:0]  i_dat,
  output logic [7:0]  o_dat,
  output logic        o_ack,
  output logic [15:0] o_sram_addr,
  output logic [7:0]  o_sram_dat,
  output logic        o_sram_dat_oe,
  input  logic [7:0]  i_sram_dat,
  output logic        o_sram_ce_n,
  output logic        o_sram_oe_n,
  output logic        o_sram_we_n
);

  localparam logic [3:0] WsLoad = 4'(WAIT_STATES);

  state_e      state_q;
  logic [3:0]  cnt_q;
  logic        we_q;
  logic [7:0]  dat_q;
  logic        ack_q;
  logic [15:0] sram_addr_q;
  logic [7:0]  sram_dat_q;
  logic        dat_oe_q;
  logic        ce_n_q;
  logic        oe_n_q;
  logic        we_n_q;

  // Every strobe is registered and set on the edge that enters the state it
  // belongs to, so the SRAM pins are glitch-free and line up with the state.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      we_q        <= 1'b0;
      dat_q       <= 8'h00;
      ack_q       <= 1'b0;
      sram_addr_q <= 16'h0000;
      sram_dat_q  <= 8'h00;
      dat_oe_q    <= 1'b0;
      ce_n_q      <= 1'b1;
      oe_n_q      <= 1'b1;
      we_n_q      <= 1'b1;
    end else begin
      ack_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (i_cs) begin
            we_q        <= i_we;
            sram_addr_q <= i_addr;
            if (i_addr >= EXCL_BASE) begin
              // Reserved window: no SRAM cycle, reads return zero
              state_q <= ACK;
              ack_q   <= 1'b1;
              if (!i_we) begin
                dat_q <= 8'h00;
              end
            end else begin
              state_q    <= SETUP;
              sram_dat_q <= i_dat;
              ce_n_q     <= 1'b0;
              oe_n_q     <= i_we;
              dat_oe_q   <= i_we;
              we_n_q     <= 1'b1;
            end
          end
        end
        SETUP: begin
          state_q <= STROBE;
          cnt_q   <= WsLoad;
          we_n_q  <= ~we_q;
        end
        STROBE: begin
          if (cnt_q == 4'd0) begin
            state_q <= ACK;
            ack_q   <= 1'b1;
            oe_n_q  <= 1'b1;
            // we_n rises while data is still driven, giving a hold cycle
            we_n_q  <= 1'b1;
            if (!we_q) begin
              dat_q <= i_sram_dat;
            end
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        ACK: begin
          state_q  <= IDLE;
          ce_n_q   <= 1'b1;
          oe_n_q   <= 1'b1;
          we_n_q   <= 1'b1;
          dat_oe_q <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign o_dat         = dat_q;
  assign o_ack         = ack_q;
  assign o_sram_addr   = sram_addr_q;
  assign o_sram_dat    = sram_dat_q;
  assign o_sram_dat_oe = dat_oe_q;
  assign o_sram_ce_n   = ce_n_q;
  assign o_sram_oe_n   = oe_n_q;
  assign o_sram_we_n   = we_n_q;

endmodule

// File: tb/tb_bus_sram_responder.sv
// ---------------------------------------------------------------------------
// tb_bus_sram_responder
// Drives the responder through directed and random bus accesses against an
// asynchronous SRAM device model, and compares every cycle of each access
// with timing and data predicted from the access rules. Two extra instances
// with WAIT_STATES=0 and 15 share the bus inputs for the latency sweep.
// ---------------------------------------------------------------------------
module tb_bus_sram_responder;

  localparam int          WS   = 2;
  localparam logic [15:0] EXCL = 16'hFFF0;

  logic        clk;
  logic        rstN;
  logic        cs;
  logic        we;
  logic [15:0] addr;
  logic [7:0]  dat;

  logic [7:0]  odat;
  logic        ack;
  logic [15:0] sramAddr;
  logic [7:0]  sramDatOut;
  logic        datOe;
  logic [7:0]  sramRd;
  logic        ceN;
  logic        oeN;
  logic        weN;

  logic [7:0]  odat0, odat15, sramDat0, sramDat15;
  logic        ack0, ack15, datOe0, datOe15;
  logic [15:0] sramAddr0, sramAddr15;
  logic        ceN0, oeN0, weN0, ceN15, oeN15, weN15;
  logic [7:0]  constSram;

  logic [7:0]  sramMem [0:65535];
  logic [7:0]  refMem [logic [15:0]];
  logic [7:0]  refOdat;
  bit          monitorOn;

  int checks;
  int passed;

  bus_sram_responder #(.WAIT_STATES(WS)) dut (
    .i_clk(clk), .i_reset(rstN), .i_cs(cs), .i_we(we), .i_addr(addr), .i_dat(dat),
    .o_dat(odat), .o_ack(ack), .o_sram_addr(sramAddr), .o_sram_dat(sramDatOut),
    .o_sram_dat_oe(datOe), .i_sram_dat(sramRd), .o_sram_ce_n(ceN),
    .o_sram_oe_n(oeN), .o_sram_we_n(weN)
  );

  bus_sram_responder #(.WAIT_STATES(0)) dut0 (
    .i_clk(clk), .i_reset(rstN), .i_cs(cs), .i_we(we), .i_addr(addr), .i_dat(dat),
    .o_dat(odat0), .o_ack(ack0), .o_sram_addr(sramAddr0), .o_sram_dat(sramDat0),
    .o_sram_dat_oe(datOe0), .i_sram_dat(constSram), .o_sram_ce_n(ceN0),
    .o_sram_oe_n(oeN0), .o_sram_we_n(weN0)
  );

  bus_sram_responder #(.WAIT_STATES(15)) dut15 (
    .i_clk(clk), .i_reset(rstN), .i_cs(cs), .i_we(we), .i_addr(addr), .i_dat(dat),
    .o_dat(odat15), .o_ack(ack15), .o_sram_addr(sramAddr15), .o_sram_dat(sramDat15),
    .o_sram_dat_oe(datOe15), .i_sram_dat(constSram), .o_sram_ce_n(ceN15),
    .o_sram_oe_n(oeN15), .o_sram_we_n(weN15)
  );

  // Free-running clock, 10 time units per period
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Asynchronous SRAM device: reads are combinational while selected and
  // output-enabled, writes land on the clock while we_n is low.
  assign sramRd = (!ceN && !oeN) ? sramMem[sramAddr] : 8'hEE;

  always @(posedge clk) begin
    if (!ceN && !weN && datOe) begin
      sramMem[sramAddr] <= sramDatOut;
    end
  end

  // Initial SRAM contents, known to both the device and the reference model
  function automatic logic [7:0] pattern(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  function automatic logic [7:0] refRead(input logic [15:0] a);
    if (refMem.exists(a)) return refMem[a];
    return pattern(a);
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $display("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
      $error("[TB] comparison %s", tag);
    end
  endtask

  // The SRAM must never see the data bus driven while it is itself driving
  // (oe_n low), and we_n may only fall while write data is on the bus.
  always @(negedge clk) begin
    if (monitorOn) begin
      checkOutput("bus contention", {62'd0, (!oeN && datOe), (!weN && !datOe)}, 64'd0);
    end
  end

  // One complete access. Cycle k is the k-th clock period after the edge
  // that latches the request; strobes follow the setup/strobe/ack timing.
  task automatic applyStimulus(input logic w, input logic [15:0] a, input logic [7:0] d,
                               input bit dropCs);
    bit         excl;
    int         last;
    logic [4:0] expVec;
    excl = (a >= EXCL);
    last = excl ? 1 : WS + 3;
    cs   = 1'b1;
    we   = w;
    addr = a;
    dat  = d;
    @(posedge clk);
    #1;
    if (dropCs) cs = 1'b0;
    we   = ~w;
    addr = 16'($urandom);
    dat  = 8'($urandom);
    for (int k = 1; k <= last; k++) begin
      @(negedge clk);
      expVec[4] = (k == last);
      expVec[3] = excl;
      expVec[2] = !(!excl && !w && k <= WS + 2);
      expVec[1] = !(!excl && w && k >= 2 && k <= WS + 2);
      expVec[0] = !excl && w;
      checkOutput($sformatf("strobes addr=%h we=%0d cycle=%0d", a, w, k),
                  {59'd0, ack, ceN, oeN, weN, datOe}, {59'd0, expVec});
      if (k == 1 && !excl) begin
        checkOutput("sram_addr", {48'd0, sramAddr}, {48'd0, a});
        if (w) checkOutput("sram_dat", {56'd0, sramDatOut}, {56'd0, d});
      end
    end
    if (!w) refOdat = excl ? 8'h00 : refRead(a);
    else if (!excl) refMem[a] = d;
    checkOutput($sformatf("o_dat addr=%h", a), {56'd0, odat}, {56'd0, refOdat});
    cs = 1'b0;
    @(negedge clk);
    checkOutput("idle after ack", {62'd0, ack, ceN}, 64'd1);
    if (w) checkOutput($sformatf("sram contents %h", a), {56'd0, sramMem[a]}, {56'd0, refRead(a)});
  endtask

  // Directed sequence followed by random accesses and the parameter sweep
  initial begin
    int         lat0;
    int         lat15;
    logic [15:0] ra;
    checks    = 0;
    passed    = 0;
    monitorOn = 1'b0;
    rstN      = 1'b0;
    cs        = 1'b0;
    we        = 1'b0;
    addr      = 16'h0000;
    dat       = 8'h00;
    constSram = 8'h5C;
    refOdat   = 8'h00;
    for (int i = 0; i < 65536; i++) sramMem[i] = pattern(16'(i));
    sramMem[16'h1234] = 8'hA5;
    refMem[16'h1234]  = 8'hA5;

    repeat (3) @(negedge clk);
    checkOutput("reset state",
                {27'd0, ack, ceN, oeN, weN, datOe, odat, sramAddr, sramDatOut},
                {27'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 16'h0000, 8'h00});
    rstN = 1'b1;
    monitorOn = 1'b1;
    @(negedge clk);

    $display("[TB] directed accesses");
    applyStimulus(1'b0, 16'h1234, 8'h00, 1'b0);
    applyStimulus(1'b1, 16'h0010, 8'h3C, 1'b1);
    applyStimulus(1'b0, 16'h0010, 8'h00, 1'b1);
    applyStimulus(1'b0, 16'hFFF0, 8'h00, 1'b0);
    applyStimulus(1'b1, 16'hFFFF, 8'h99, 1'b0);
    applyStimulus(1'b0, 16'hFFEF, 8'h00, 1'b1);

    $display("[TB] back-to-back reads");
    cs   = 1'b1;
    we   = 1'b0;
    addr = 16'h0001;
    @(posedge clk);
    #1;
    addr = 16'h0002;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      checkOutput($sformatf("b2b ack cycle=%0d", k), {63'd0, ack}, {63'd0, (k == 5 || k == 11)});
      if (k == 5)  checkOutput("b2b data 1", {56'd0, odat}, {56'd0, refRead(16'h0001)});
      if (k == 11) checkOutput("b2b data 2", {56'd0, odat}, {56'd0, refRead(16'h0002)});
      if (k == 7) cs = 1'b0;
    end
    refOdat = refRead(16'h0002);

    $display("[TB] random accesses");
    for (int n = 0; n < 16; n++) begin
      if ($urandom_range(0, 7) == 0) ra = EXCL + 16'($urandom_range(0, 15));
      else ra = 16'h0100 + 16'($urandom_range(0, 31));
      applyStimulus(1'($urandom_range(0, 1)), ra, 8'($urandom), 1'($urandom_range(0, 1)));
    end

    $display("[TB] reset during write strobe");
    cs   = 1'b1;
    we   = 1'b1;
    addr = 16'h0020;
    dat  = 8'h77;
    @(posedge clk);
    #1;
    cs = 1'b0;
    repeat (2) @(negedge clk);
    rstN = 1'b0;
    @(negedge clk);
    checkOutput("abort strobes", {60'd0, ack, ceN, weN, datOe}, {60'd0, 1'b0, 1'b1, 1'b1, 1'b0});
    checkOutput("abort o_dat", {56'd0, odat}, 64'd0);
    rstN = 1'b1;
    refOdat = 8'h00;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      checkOutput("no ack after abort", {63'd0, ack}, 64'd0);
    end
    applyStimulus(1'b0, 16'h1234, 8'h00, 1'b1);

    $display("[TB] wait-state sweep");
    monitorOn = 1'b0;
    rstN = 1'b0;
    repeat (2) @(negedge clk);
    rstN = 1'b1;
    monitorOn = 1'b1;
    @(negedge clk);
    cs   = 1'b1;
    we   = 1'b0;
    addr = 16'h0005;
    @(posedge clk);
    #1;
    cs = 1'b0;
    lat0  = 0;
    lat15 = 0;
    for (int k = 1; k <= 25; k++) begin
      @(negedge clk);
      if (ack0 && lat0 == 0) lat0 = k;
      if (ack15 && lat15 == 0) lat15 = k;
    end
    checkOutput("latency WS=0", 64'(lat0), 64'd3);
    checkOutput("latency WS=15", 64'(lat15), 64'd18);
    checkOutput("o_dat WS=0", {56'd0, odat0}, {56'd0, constSram});
    checkOutput("o_dat WS=15", {56'd0, odat15}, {56'd0, constSram});
    checkOutput("o_dat WS=2", {56'd0, odat}, {56'd0, refRead(16'h0005)});

    monitorOn = 1'b0;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
